// File: rtl/ring_shifter_n_if.sv
// Button, control and ring outputs of ring_shifter_n bundled as one port.
// The master side drives the raw buttons and controls; the slave side is the rotator.
interface ring_shifter_n_if #(
    parameter int WIDTH = 9
);
    logic             btn_l;
    logic             btn_r;
    logic             auto_en;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] q;
    logic             run;
    logic             dir;
    logic             step;

    modport master (
        output btn_l, btn_r, auto_en, load, load_data,
        input  q, run, dir, step
    );

    modport slave (
        input  btn_l, btn_r, auto_en, load, load_data,
        output q, run, dir, step
    );
endinterface

// File: rtl/ring_shifter_n.sv
// N-bit ring rotator driven by two debounced push-buttons, with single-step,
// divided auto-rotation and parallel load. Everything runs on clk.
module ring_shifter_n #(
    parameter int                 WIDTH           = 9,
    parameter logic [WIDTH-1:0]   INIT            = {1'b1, {(WIDTH-1){1'b0}}},
    parameter int                 DEBOUNCE_CYCLES = 4,
    parameter int                 AUTO_DIV        = 8
) (
    input  logic             clk,
    input  logic             rst,
    ring_shifter_n_if.slave  bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = $clog2(AUTO_DIV);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PS_LAST = PW'(AUTO_DIV - 1);

    typedef enum logic [1:0] {HOLD, RUN_L, RUN_R} state_t;

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]    raw, sync1, sync2, level, level_d, press;
    logic [CW-1:0] db_cnt [2];

    assign raw   = {bus.btn_r, bus.btn_l};
    assign press = level & ~level_d;

    // NOTE: every register here uses <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
        end
    end

    state_t           state, state_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             rot_en, rot_left, one_press;
    state_t           press_state;

    assign one_press   = press[0] ^ press[1];
    assign press_state = press[0] ? RUN_L : RUN_R;

    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        q_nxt     = bus.q;
        rot_en    = 1'b0;
        rot_left  = 1'b0;

        if (bus.load) begin
            q_nxt     = bus.load_data;
            state_nxt = HOLD;
            presc_nxt = '0;
        end else if (one_press) begin
            presc_nxt = '0;
            if (state == press_state) begin
                state_nxt = HOLD;
            end else begin
                rot_en    = 1'b1;
                rot_left  = press[0];
                state_nxt = bus.auto_en ? press_state : HOLD;
            end
        end else if (state != HOLD) begin
            if (!bus.auto_en) begin
                state_nxt = HOLD;
                presc_nxt = '0;
            end else if (presc == PS_LAST) begin
                rot_en    = 1'b1;
                rot_left  = (state == RUN_L);
                presc_nxt = '0;
            end else begin
                presc_nxt = presc + PW'(1);
            end
        end

        if (rot_en) begin
            q_nxt = rot_left ? {bus.q[WIDTH-2:0], bus.q[WIDTH-1]}
                             : {bus.q[0], bus.q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HOLD;
            presc    <= '0;
            bus.q    <= INIT;
            bus.dir  <= 1'b0;
            bus.step <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            bus.q    <= q_nxt;
            bus.step <= rot_en;
            if (rot_en) bus.dir <= rot_left;
        end
    end

    assign bus.run = (state != HOLD);
endmodule

// File: tb/tb_ring_shifter_n.sv
// Bench for ring_shifter_n: a cycle model derived from the behavioural rules is
// compared every cycle, with literal checkpoints along a directed scenario.
module tb_ring_shifter_n;
    localparam int W   = 9;
    localparam int DB  = 4;
    localparam int DIV = 8;
    localparam logic [W-1:0] INIT = 9'b100000000;

    logic clk, rst;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 0;

    ring_shifter_n_if #(.WIDTH(W)) bus ();

    ring_shifter_n #(
        .WIDTH(W), .INIT(INIT), .DEBOUNCE_CYCLES(DB), .AUTO_DIV(DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rot(input logic [W-1:0] v, input bit left);
        int unsigned x, mask;
        mask = (1 << W) - 1;
        x    = v;
        if (left) x = ((x << 1) | (x >> (W - 1))) & mask;
        else      x = (x >> 1) | ((x & 1) << (W - 1));
        return x[W-1:0];
    endfunction

    // Model state: mode is 0 idle, +1 running left, -1 running right.
    logic [W-1:0] m_q;
    int  m_mode, m_since;
    bit  m_dir, m_step;
    bit  m_s1 [2], m_s2 [2], m_lvl [2], m_prev [2];
    int  m_mis [2];

    always @(posedge clk) begin
        bit pl, pr, rotated, raw [2];
        int d;
        raw[0] = bus.btn_l;
        raw[1] = bus.btn_r;
        if (rst) begin
            m_q = INIT; m_mode = 0; m_since = 0; m_dir = 0; m_step = 0;
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_prev[b] = 0; m_mis[b] = 0;
            end
        end else begin
            pl = m_lvl[0] && !m_prev[0];
            pr = m_lvl[1] && !m_prev[1];
            rotated = 0;
            if (bus.load) begin
                m_q = bus.load_data; m_mode = 0; m_since = 0;
            end else if (pl && pr) begin
                rotated = 0;
            end else if (pl || pr) begin
                d = pl ? 1 : -1;
                m_since = 0;
                if (m_mode == d) begin
                    m_mode = 0;
                end else begin
                    m_q = rot(m_q, pl); rotated = 1; m_dir = pl;
                    m_mode = bus.auto_en ? d : 0;
                end
            end else if (m_mode != 0) begin
                if (!bus.auto_en) begin
                    m_mode = 0; m_since = 0;
                end else begin
                    m_since++;
                    if (m_since == DIV) begin
                        m_q = rot(m_q, m_mode > 0); rotated = 1; m_dir = (m_mode > 0);
                        m_since = 0;
                    end
                end
            end
            m_step = rotated;
            // Accepted level flips after DB consecutive synchronised mismatches.
            for (int b = 0; b < 2; b++) begin
                m_prev[b] = m_lvl[b];
                if (m_s2[b] != m_lvl[b]) begin
                    m_mis[b]++;
                    if (m_mis[b] == DB) begin m_lvl[b] = m_s2[b]; m_mis[b] = 0; end
                end else begin
                    m_mis[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("model_q",    32'(bus.q),    32'(m_q));
            check("model_run",  32'(bus.run),  32'(m_mode != 0));
            check("model_dir",  32'(bus.dir),  32'(m_dir));
            check("model_step", 32'(bus.step), 32'(m_step));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] q, input bit run, input bit dir);
        check({tag, "_q"},   32'(bus.q),   32'(q));
        check({tag, "_run"}, 32'(bus.run), 32'(run));
        check({tag, "_dir"}, 32'(bus.dir), 32'(dir));
    endtask

    initial begin
        rst = 1'b1;
        bus.btn_l = 0; bus.btn_r = 0; bus.auto_en = 0; bus.load = 0; bus.load_data = '0;
        cyc(1);
        expect_out("reset", INIT, 0, 0);
        check("reset_step", 32'(bus.step), 32'd0);
        cmp_en = 1;

        // Single left step with the default debounce latency.
        rst = 1'b0; bus.btn_l = 1;
        cyc(6); expect_out("t1_pre", INIT, 0, 0);
        cyc(1); expect_out("t1_rot", 9'b000000001, 0, 1);
        check("t1_step_hi", 32'(bus.step), 32'd1);
        cyc(1); check("t1_step_lo", 32'(bus.step), 32'd0);
        cyc(10); expect_out("t1_hold", 9'b000000001, 0, 1);
        bus.btn_l = 0; cyc(8);

        // Short glitch is rejected, then a held press steps right.
        bus.btn_r = 1; cyc(3); bus.btn_r = 0;
        cyc(10); expect_out("t2_glitch", 9'b000000001, 0, 1);
        bus.btn_r = 1;
        cyc(6); expect_out("t2_pre", 9'b000000001, 0, 1);
        cyc(1); expect_out("t2_rot", 9'b100000000, 0, 0);
        bus.btn_r = 0; cyc(8);

        // Auto-rotation right with wrap, then stopped by a second right press.
        bus.auto_en = 1; bus.btn_r = 1;
        cyc(6); expect_out("t3_pre", 9'b100000000, 0, 0);
        cyc(1); expect_out("t3_enter", 9'b010000000, 1, 0);
        check("t3_step", 32'(bus.step), 32'd1);
        bus.btn_r = 0;
        cyc(7); expect_out("t3_wait", 9'b010000000, 1, 0);
        cyc(1); expect_out("t3_auto1", 9'b001000000, 1, 0);
        for (int i = 1; i <= 6; i++) begin
            logic [W-1:0] e;
            e = 9'b001000000 >> i;
            cyc(8); expect_out("t3_auto", e, 1, 0);
        end
        cyc(8); expect_out("t3_wrap", 9'b100000000, 1, 0);
        bus.btn_r = 1;
        cyc(6); expect_out("t3_stop_pre", 9'b100000000, 1, 0);
        cyc(1); expect_out("t3_stop", 9'b100000000, 0, 0);
        cyc(10); expect_out("t3_frozen", 9'b100000000, 0, 0);

        // Reverse direction while running.
        bus.btn_r = 0; cyc(8);
        bus.btn_r = 1;
        cyc(7); expect_out("t4_run_r", 9'b010000000, 1, 0);
        bus.btn_r = 0; bus.btn_l = 1;
        cyc(6); expect_out("t4_pre", 9'b010000000, 1, 0);
        cyc(1); expect_out("t4_rev", 9'b100000000, 1, 1);
        cyc(7); expect_out("t4_wait", 9'b100000000, 1, 1);
        cyc(1); expect_out("t4_auto_l", 9'b000000001, 1, 1);

        // Load overrides the run; simultaneous presses do nothing.
        bus.btn_l = 0; bus.load = 1; bus.load_data = 9'b000010001;
        cyc(1); expect_out("t5_load", 9'b000010001, 0, 1);
        check("t5_step", 32'(bus.step), 32'd0);
        bus.load = 0;
        cyc(10); expect_out("t5_hold", 9'b000010001, 0, 1);
        bus.btn_l = 1; bus.btn_r = 1;
        cyc(20); expect_out("t5_both", 9'b000010001, 0, 1);

        // Reset mid-run while a button bounces, then debounce from scratch.
        bus.btn_l = 0; bus.btn_r = 0; cyc(10);
        bus.btn_r = 1;
        cyc(7); expect_out("t6_run", 9'b100001000, 1, 0);
        bus.btn_r = 0; bus.btn_l = 1; cyc(1);
        bus.btn_l = 0; cyc(1);
        bus.btn_l = 1; cyc(1);
        rst = 1; cyc(1);
        expect_out("t6_rst", INIT, 0, 0);
        check("t6_rst_step", 32'(bus.step), 32'd0);
        rst = 0;
        cyc(6); expect_out("t6_pre", INIT, 0, 0);
        cyc(1); expect_out("t6_rot", 9'b000000001, 1, 1);
        cyc(5);

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
